// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm ring controller:
//   - FSM state encodings (IDLE, RING, SNOOZE, DONE) and the state enum
//   - CUR_TIME / ALARM_TIME field positions: HOUR [16:12], MIN [11:6], SEC [5:0]
//   - TIME_W, the packed time width
//   - pack_time(), which builds a packed time word from its fields
// -----------------------------------------------------------------------------
package alarm_pkg;

  localparam int TIME_W  = 17;

  localparam int HOUR_HI = 16;
  localparam int HOUR_LO = 12;
  localparam int MIN_HI  = 11;
  localparam int MIN_LO  = 6;
  localparam int SEC_HI  = 5;
  localparam int SEC_LO  = 0;

  localparam logic [1:0] ENC_IDLE   = 2'd0;
  localparam logic [1:0] ENC_RING   = 2'd1;
  localparam logic [1:0] ENC_SNOOZE = 2'd2;
  localparam logic [1:0] ENC_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ENC_IDLE,
    S_RING   = ENC_RING,
    S_SNOOZE = ENC_SNOOZE,
    S_DONE   = ENC_DONE
  } alarm_state_t;

  function automatic logic [TIME_W-1:0] pack_time(input logic [4:0] hour,
                                                  input logic [5:0] min,
                                                  input logic [5:0] sec);
    logic [TIME_W-1:0] t;
    t                 = '0;
    t[HOUR_HI:HOUR_LO] = hour;
    t[MIN_HI:MIN_LO]   = min;
    t[SEC_HI:SEC_LO]   = sec;
    return t;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// -----------------------------------------------------------------------------
// alarm_tone_gen
// Buzzer waveform: a square-wave tone gated by a 1 s on / 1 s off beat.
// Ports:
//   CLK       in  system clock, posedge
//   RESET     in  synchronous, active-high
//   en        in  high while the alarm rings; gates output and advances tone
//   restart   in  one-cycle pulse on RING entry: tone phase 0, beat on
//   TICK_1HZ  in  one-cycle pulse per second; flips the beat while enabled
//   BUZZER    out tone & beat & en
// -----------------------------------------------------------------------------
module alarm_tone_gen #(
  parameter int TONE_HALF_CLKS = 12500
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic restart,
  input  logic TICK_1HZ,
  output logic BUZZER
);

  localparam int DIV_W = (TONE_HALF_CLKS > 1) ? $clog2(TONE_HALF_CLKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TONE_HALF_CLKS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tone;
  logic             beat;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt <= '0;
      tone    <= 1'b0;
      beat    <= 1'b0;
    end else if (restart) begin
      div_cnt <= '0;
      tone    <= 1'b0;
      beat    <= 1'b1;
    end else if (en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        tone    <= ~tone;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (TICK_1HZ) begin
        beat <= ~beat;
      end
    end
  end

  // en comes straight from the registered state, so the buzzer drops in the
  // same cycle the controller leaves RING.
  assign BUZZER = en & tone & beat;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ring_ctrl
// Alarm sequencer: detects CUR_TIME == ALARM_TIME on the 1 Hz tick, rings the
// buzzer, and handles stop, snooze, ring timeout and re-arm.
// Build option: define ALARM_SNOOZE_EN to build the SNOOZE state. Without it,
// KEY_SNOOZE behaves as KEY_STOP and SNOOZING / SNOOZE_LEFT are tied to 0.
// Ports:
//   CLK            in   system clock, posedge
//   RESET          in   synchronous, active-high
//   TICK_1HZ       in   one-cycle pulse per second, aligned with CUR_TIME
//   CUR_TIME       in   {hour[16:12], min[11:6], sec[5:0]}
//   ALARM_TIME     in   same packing
//   ALARM_ENABLE   in   level; low forces IDLE
//   ALARM_SETTING  in   level; high blocks a new match
//   KEY_STOP       in   one-cycle pulse
//   KEY_SNOOZE     in   one-cycle pulse
//   BUZZER         out  tone output, only in RING
//   RINGING        out  high in RING
//   SNOOZING       out  high in SNOOZE
//   SNOOZE_LEFT    out  snoozes remaining this event
//   MISSED         out  sticky: last event ended by timeout
// -----------------------------------------------------------------------------
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_HALF_CLKS = 12500
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              TICK_1HZ,
  input  logic [TIME_W-1:0] CUR_TIME,
  input  logic [TIME_W-1:0] ALARM_TIME,
  input  logic              ALARM_ENABLE,
  input  logic              ALARM_SETTING,
  input  logic              KEY_STOP,
  input  logic              KEY_SNOOZE,
  output logic              BUZZER,
  output logic              RINGING,
  output logic              SNOOZING,
  output logic [3:0]        SNOOZE_LEFT,
  output logic              MISSED
);

  localparam int RING_W = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_TIMEOUT_S);

  alarm_state_t      state, state_nxt;
  logic [RING_W-1:0] ring_cnt, ring_cnt_nxt;
  logic              missed, missed_nxt;
  logic              match;
  logic              restart;

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_S + 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_S);

  logic [SNZ_W-1:0] snz_cnt, snz_cnt_nxt;
  logic [3:0]       snooze_left, snooze_left_nxt;
`endif

  assign match = (CUR_TIME == ALARM_TIME) & ALARM_ENABLE & ~ALARM_SETTING;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      ring_cnt    <= '0;
      missed      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt     <= '0;
      snooze_left <= '0;
`endif
    end else begin
      state       <= state_nxt;
      ring_cnt    <= ring_cnt_nxt;
      missed      <= missed_nxt;
`ifdef ALARM_SNOOZE_EN
      snz_cnt     <= snz_cnt_nxt;
      snooze_left <= snooze_left_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    ring_cnt_nxt    = ring_cnt;
    missed_nxt      = missed;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_nxt     = snz_cnt;
    snooze_left_nxt = snooze_left;
`endif

    if (!ALARM_ENABLE) begin
      // Disabling the alarm abandons the event; MISSED keeps its history.
      state_nxt       = S_IDLE;
      ring_cnt_nxt    = '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_nxt     = '0;
      snooze_left_nxt = '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (TICK_1HZ && match) begin
            state_nxt       = S_RING;
            ring_cnt_nxt    = RING_LOAD;
            missed_nxt      = 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_left_nxt = 4'(MAX_SNOOZE);
`endif
          end
        end

        S_RING: begin
          if (KEY_STOP) begin
            state_nxt = S_DONE;
`ifdef ALARM_SNOOZE_EN
          end else if (KEY_SNOOZE && (snooze_left != 4'd0)) begin
            state_nxt       = S_SNOOZE;
            snooze_left_nxt = snooze_left - 4'd1;
            snz_cnt_nxt     = SNZ_LOAD;
`else
          end else if (KEY_SNOOZE) begin
            state_nxt = S_DONE;
`endif
          end else if (TICK_1HZ && (ring_cnt != '0)) begin
            // An exhausted snooze budget makes KEY_SNOOZE fall through here,
            // so the tick still counts in that cycle.
            ring_cnt_nxt = ring_cnt - 1'b1;
            if (ring_cnt == RING_W'(1)) begin
              state_nxt  = S_DONE;
              missed_nxt = 1'b1;
            end
          end
        end

`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          if (KEY_STOP) begin
            state_nxt = S_DONE;
          end else if (TICK_1HZ && (snz_cnt != '0)) begin
            snz_cnt_nxt = snz_cnt - 1'b1;
            if (snz_cnt == SNZ_W'(1)) begin
              state_nxt    = S_RING;
              ring_cnt_nxt = RING_LOAD;
            end
          end
        end
`endif

        S_DONE: begin
          // Hold here until the matching second has passed so the same
          // match cannot retrigger the alarm.
          if (!match) begin
            state_nxt       = S_IDLE;
`ifdef ALARM_SNOOZE_EN
            snooze_left_nxt = '0;
`endif
          end
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign restart = (state_nxt == S_RING) && (state != S_RING);

  alarm_tone_gen #(
    .TONE_HALF_CLKS (TONE_HALF_CLKS)
  ) u_tone (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (state == S_RING),
    .restart  (restart),
    .TICK_1HZ (TICK_1HZ),
    .BUZZER   (BUZZER)
  );

  assign RINGING = (state == S_RING);
  assign MISSED  = missed;

`ifdef ALARM_SNOOZE_EN
  assign SNOOZING    = (state == S_SNOOZE);
  assign SNOOZE_LEFT = snooze_left;
`else
  assign SNOOZING    = 1'b0;
  assign SNOOZE_LEFT = 4'd0;
`endif

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_ring_ctrl
// Scoreboard bench: the stimulus side steps a behavioural reference model per
// cycle and queues the expected outputs; an independent monitor pops one entry
// per clock and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_alarm_ring_ctrl;
  import alarm_pkg::*;

  localparam int RING_TIMEOUT_S = 5;
  localparam int SNOOZE_S       = 3;
  localparam int MAX_SNOOZE     = 2;
  localparam int TONE_HALF_CLKS = 4;

`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2, M_DONE = 3;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              TICK_1HZ = 1'b0;
  logic [TIME_W-1:0] CUR_TIME = '0;
  logic [TIME_W-1:0] ALARM_TIME = '0;
  logic              ALARM_ENABLE = 1'b0;
  logic              ALARM_SETTING = 1'b0;
  logic              KEY_STOP = 1'b0;
  logic              KEY_SNOOZE = 1'b0;
  logic              BUZZER, RINGING, SNOOZING, MISSED;
  logic [3:0]        SNOOZE_LEFT;

  always #5 CLK = ~CLK;

  alarm_ring_ctrl #(
    .RING_TIMEOUT_S (RING_TIMEOUT_S),
    .SNOOZE_S       (SNOOZE_S),
    .MAX_SNOOZE     (MAX_SNOOZE),
    .TONE_HALF_CLKS (TONE_HALF_CLKS)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .TICK_1HZ      (TICK_1HZ),
    .CUR_TIME      (CUR_TIME),
    .ALARM_TIME    (ALARM_TIME),
    .ALARM_ENABLE  (ALARM_ENABLE),
    .ALARM_SETTING (ALARM_SETTING),
    .KEY_STOP      (KEY_STOP),
    .KEY_SNOOZE    (KEY_SNOOZE),
    .BUZZER        (BUZZER),
    .RINGING       (RINGING),
    .SNOOZING      (SNOOZING),
    .SNOOZE_LEFT   (SNOOZE_LEFT),
    .MISSED        (MISSED)
  );

  typedef struct packed {
    logic       ringing;
    logic       snoozing;
    logic [3:0] left;
    logic       missed;
    logic       buzzer;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Level inputs staged here and applied together at the next drive.
  logic              rst_v = 1'b1;
  logic              en_v  = 1'b0;
  logic              set_v = 1'b0;
  logic [TIME_W-1:0] cur_v = '0;
  logic [TIME_W-1:0] alm_v = '0;
  int                t_sec = 0;

  // Reference model: mode plus plain integer counters. The buzzer is derived
  // from how long the current ring has lasted and how many ticks it has seen.
  int m_mode = M_IDLE, m_ring_left = 0, m_snz_left = 0, m_snoozes = 0;
  int m_missed = 0, m_age = 0, m_ticks = 0;

  function automatic logic [TIME_W-1:0] to_time(input int t);
    return pack_time(5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60));
  endfunction

  function automatic void enter_ring();
    m_mode      = M_RING;
    m_ring_left = RING_TIMEOUT_S;
    m_age       = 0;
    m_ticks     = 0;
  endfunction

  function automatic void model_step(input bit tick, input bit stop, input bit snz);
    bit match;
    match = (cur_v == alm_v) && en_v && !set_v;
    if (rst_v) begin
      m_mode = M_IDLE; m_ring_left = 0; m_snz_left = 0; m_snoozes = 0;
      m_missed = 0; m_age = 0; m_ticks = 0;
    end else if (!en_v) begin
      m_mode = M_IDLE; m_snoozes = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (tick && match) begin
          enter_ring();
          m_snoozes = MAX_SNOOZE;
          m_missed  = 0;
        end
        M_RING: begin
          if (stop) m_mode = M_DONE;
          else if (snz && !SNZ_ON) m_mode = M_DONE;
          else if (snz && m_snoozes > 0) begin
            m_mode = M_SNOOZE; m_snoozes--; m_snz_left = SNOOZE_S;
          end else begin
            m_age++;
            if (tick) begin
              m_ticks++;
              m_ring_left--;
              if (m_ring_left == 0) begin m_mode = M_DONE; m_missed = 1; end
            end
          end
        end
        M_SNOOZE: begin
          if (stop) m_mode = M_DONE;
          else if (tick) begin
            m_snz_left--;
            if (m_snz_left == 0) enter_ring();
          end
        end
        default: if (!match) begin m_mode = M_IDLE; m_snoozes = 0; end
      endcase
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.ringing  = (m_mode == M_RING);
    e.snoozing = (m_mode == M_SNOOZE);
    e.left     = SNZ_ON ? 4'(m_snoozes) : 4'd0;
    e.missed   = (m_missed != 0);
    e.buzzer   = (m_mode == M_RING) && (((m_age / TONE_HALF_CLKS) % 2) == 1)
                 && ((m_ticks % 2) == 0);
    return e;
  endfunction

  task automatic drive(input bit tick, input bit stop, input bit snz);
    @(negedge CLK);
    RESET         = rst_v;
    ALARM_ENABLE  = en_v;
    ALARM_SETTING = set_v;
    CUR_TIME      = cur_v;
    ALARM_TIME    = alm_v;
    TICK_1HZ      = tick;
    KEY_STOP      = stop;
    KEY_SNOOZE    = snz;
    model_step(tick, stop, snz);
    sb_q.push_back(model_out());
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sec_tick();
    t_sec++;
    cur_v = to_time(t_sec);
    drive(1'b1, 1'b0, 1'b0);
  endtask

  // Move to one second before the alarm, then tick into the match.
  task automatic ring_up();
    t_sec = 26999;
    cur_v = to_time(t_sec);
    idle_n(2);
    sec_tick();
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(posedge CLK) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("RINGING",     {3'b0, RINGING},  {3'b0, mon_e.ringing});
      chk("SNOOZING",    {3'b0, SNOOZING}, {3'b0, mon_e.snoozing});
      chk("SNOOZE_LEFT", SNOOZE_LEFT,      mon_e.left);
      chk("MISSED",      {3'b0, MISSED},   {3'b0, mon_e.missed});
      chk("BUZZER",      {3'b0, BUZZER},   {3'b0, mon_e.buzzer});
    end
  end

  initial begin
    int s;
    // Reset
    rst_v = 1'b1;
    idle_n(3);
    rst_v = 1'b0;
    en_v  = 1'b1;
    alm_v = to_time(27000);

    // 1: match, ring with tone, stop, re-arm after the second passes
    ring_up();
    idle_n(12);
    drive(1'b0, 1'b1, 1'b0);
    idle_n(3);
    sec_tick();
    idle_n(2);

    // 2: unattended timeout then a fresh event clears MISSED
    ring_up();
    repeat (RING_TIMEOUT_S) begin idle_n(3); sec_tick(); end
    idle_n(3);
    ring_up();
    idle_n(5);
    drive(1'b0, 1'b1, 1'b0);
    idle_n(2);

    // 3: snooze twice, third snooze is ignored
    ring_up();
    idle_n(2);
    drive(1'b0, 1'b0, 1'b1);
    repeat (SNOOZE_S) begin idle_n(2); sec_tick(); end
    idle_n(3);
    drive(1'b0, 1'b0, 1'b1);
    repeat (SNOOZE_S) begin idle_n(2); sec_tick(); end
    idle_n(2);
    drive(1'b0, 1'b0, 1'b1);
    idle_n(6);
    drive(1'b0, 1'b1, 1'b0);
    idle_n(2);

    // 4: stop and snooze together
    ring_up();
    idle_n(3);
    drive(1'b0, 1'b1, 1'b1);
    idle_n(3);

    // 5: enable drop mid-snooze, reset mid-ring
    ring_up();
    drive(1'b0, 1'b0, 1'b1);
    idle_n(2);
    en_v = 1'b0;
    idle_n(3);
    en_v = 1'b1;
    idle_n(2);
    ring_up();
    idle_n(5);
    rst_v = 1'b1;
    idle_n(2);
    rst_v = 1'b0;
    idle_n(2);

    // 6: setting blocks a match; setting during ring does not cancel
    set_v = 1'b1;
    t_sec = 26999;
    cur_v = to_time(t_sec);
    idle_n(2);
    sec_tick();
    idle_n(3);
    set_v = 1'b0;
    ring_up();
    set_v = 1'b1;
    idle_n(3);
    sec_tick();
    idle_n(2);
    set_v = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    idle_n(2);

    // Randomized: seconds cycle through a 4 s window around the alarm
    alm_v = to_time(28802);
    s     = 0;
    cur_v = to_time(28800);
    for (int i = 0; i < 3000; i++) begin
      bit tk, sp, sz;
      tk = ($urandom_range(3) == 0);
      sp = ($urandom_range(39) == 0);
      sz = ($urandom_range(14) == 0);
      if ($urandom_range(199) == 0) en_v = ~en_v;
      if ($urandom_range(149) == 0) set_v = ~set_v;
      rst_v = ($urandom_range(499) == 0);
      if (tk) begin
        s     = (s + 1) % 4;
        cur_v = to_time(28800 + s);
      end
      drive(tk, sp, sz);
    end
    rst_v = 1'b0;
    idle_n(2);

    @(posedge CLK);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
